// File: rtl/arbitro_wrr.sv
// Weighted round-robin arbiter moving words from 4 input FIFOs to 4 output FIFOs.
// Pops are combinational; the push side is a two-stage registered pipeline.
module arbitro_wrr #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [4*WEIGHT_WIDTH-1:0] weights,
    input  logic [3:0]                FIFO_empty,
    input  logic [3:0]                Almost_full,
    input  logic [4*DATA_WIDTH-1:0]   data_in,
    output logic [3:0]                Pops,
    output logic [3:0]                Push,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      idle
);

    typedef enum logic [1:0] {INIT, IDLE, ACTIVE} state_t;

    state_t                  state, state_next;
    logic [WEIGHT_WIDTH-1:0] wt [4];
    logic [WEIGHT_WIDTH-1:0] cnt;
    logic [1:0]              ptr, ptr_next, sel_d;
    logic                    v_d;
    logic [3:0]              eligible;
    logic                    stall, any_eligible, pop, last_grant, found;
    logic [DATA_WIDTH-1:0]   word;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++)
            eligible[i] = !FIFO_empty[i] && (wt[i] != '0);
        stall        = |Almost_full;
        any_eligible = |eligible;
        last_grant   = ({1'b0, cnt} + 1'b1) == {1'b0, wt[ptr]};
        word         = data_in[int'(sel_d)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Circular search ptr+1..ptr+3 then ptr itself; holds if nothing eligible.
    always_comb begin
        ptr_next = ptr;
        found    = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!found && eligible[2'(ptr + 2'(k))]) begin
                ptr_next = 2'(ptr + 2'(k));
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        Pops = '0;
        if (!reset && state == ACTIVE && eligible[ptr] && !stall && !init)
            Pops[ptr] = 1'b1;
        pop = |Pops;
    end

    always_comb begin
        if (init)
            state_next = INIT;
        else if (state == INIT)
            state_next = IDLE;
        else
            state_next = any_eligible ? ACTIVE : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idle  <= 1'b1;
            ptr   <= '0;
            cnt   <= '0;
            wt[0] <= WEIGHT_WIDTH'(4);
            wt[1] <= WEIGHT_WIDTH'(3);
            wt[2] <= WEIGHT_WIDTH'(2);
            wt[3] <= WEIGHT_WIDTH'(1);
        end else begin
            state <= state_next;
            idle  <= (state_next != ACTIVE);
            if (init || state == INIT) begin
                for (int unsigned i = 0; i < 4; i++)
                    wt[i] <= weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                ptr <= '0;
                cnt <= '0;
            end else if (state == ACTIVE && !stall) begin
                if (eligible[ptr] && !last_grant) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    ptr <= ptr_next;
                    cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_d      <= 1'b0;
            sel_d    <= '0;
            Push     <= '0;
            data_out <= '0;
        end else begin
            v_d   <= pop;
            sel_d <= ptr;
            if (v_d) begin
                data_out <= word;
                Push     <= 4'b0001 << word[1:0];
            end else begin
                Push <= '0;
            end
        end
    end

endmodule

// File: doc/arbitro_wrr.md
Name: arbitro_wrr

Overview:
- Weighted round-robin arbiter and transfer sequencer between 4 input (transmit) FIFOs and 4 output (receive) FIFOs of the switch.
- Each cycle, selects at most one non-empty input FIFO, pops it, and forwards the popped word to the output FIFO addressed by the word's destination bits.
- Per-FIFO weights are run-time programmable.
- Throttles all pops while any output FIFO is almost full.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word; bits [1:0] carry the destination.
- WEIGHT_WIDTH, 3, width of each per-FIFO weight.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  weight-load/hold request.
- weights  input  4*WEIGHT_WIDTH  weight of FIFO i in slice [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- FIFO_empty  input  4  empty flags of the input FIFOs.
- Almost_full  input  4  almost-full flags of the output FIFOs.
- data_in  input  4*DATA_WIDTH  read data of input FIFO i in slice i; valid the cycle after that FIFO is popped.
- Pops  output  4  one-hot pop strobes to the input FIFOs; combinational.
- Push  output  4  one-hot push strobes to the output FIFOs; registered.
- data_out  output  DATA_WIDTH  word written to the output FIFOs; registered.
- idle  output  1  high when nothing is eligible to pop; registered.

Behaviour:
- Reset (async): state=IDLE, ptr=0, cnt=0, weights reg={1,2,3,4} (w3..w0), Push=0, data_out=0, idle=1, pipeline valid=0. Pops=0 while reset is high.
- States: INIT, IDLE, ACTIVE.
  - init=1 in any state -> INIT. In INIT: weight reg loads weights every cycle; ptr=0; cnt=0; Pops=0.
  - init falling -> IDLE.
- eligible(i) = !FIFO_empty[i] && weight[i]!=0.
- stall = |Almost_full.
- IDLE -> ACTIVE when any eligible(i). ACTIVE -> IDLE when no eligible(i).
- idle = (next state != ACTIVE).
- Pops[ptr] = (state==ACTIVE) && eligible(ptr) && !stall && !init. All other bits are 0. At most one bit is ever set.
- On a clock edge with a pop:
  - cnt <= cnt+1.
  - If cnt+1 == weight[ptr], or the FIFO is about to empty (not knowable; ignore), then ptr advances and cnt <= 0.
- ptr advance: next ptr = first eligible FIFO searched circularly from ptr+1 through ptr+3, then ptr itself. If none is found, ptr holds.
- If ptr is not eligible in ACTIVE (FIFO went empty), ptr advances on the same edge with cnt <= 0. No idle cycle is inserted between grants.
- While stall is high, ptr and cnt hold. Arbitration resumes exactly where it stopped.
- Weight 0 excludes that FIFO entirely.
- cnt is WEIGHT_WIDTH bits and never exceeds weight-1.
- Datapath pipeline:
  - Cycle N: Pops asserted; sel_d <= ptr; v_d <= 1.
  - Cycle N+1: data_in[sel_d] is valid. On that edge, if v_d: data_out <= word; Push <= onehot(word[1:0]).
  - Otherwise Push <= 0 and data_out holds.
  - Push is high for exactly one cycle per popped word. Latency from pop cycle to push cycle is 2.
- Back-to-back pops produce back-to-back pushes.
- Up to 2 words are in flight, so the output FIFO almost-full threshold must leave at least 2 free entries.
- init or stall mid-transfer stops new pops only; in-flight words still push.
- reset mid-transfer drops in-flight words; Push=0 immediately.
- Weight changes take effect only via INIT.

Test Plan:
- Reset released, init=0, all FIFOs non-empty, no stall -> Pops sequence 0001 x4, 0010 x3, 0100 x2, 1000 x1, repeating every 10 cycles; idle=0.
- FIFO_empty=0010 held, defaults -> sequence 0001 x4, 0100 x2, 1000 x1, period 7, no bubble cycles.
- Almost_full=0100 for 3 cycles on the 2nd grant of FIFO0 -> Pops=0 for those 3 cycles. On release, FIFO0 gets its remaining 3 grants, then FIFO1.
- FIFO0 popped in cycle N with data_in[7:0]=8'hA6 in N+1 -> in cycle N+2 data_out=8'hA6 and Push=0100 for one cycle. 8'h03 -> Push=1000.
- init pulse with w0=5, w1=0, w2=1, w3=0, all FIFOs non-empty -> Pops=0 during init. Afterwards: 0001 x5, 0100 x1, repeating; FIFO1 and FIFO3 are never popped.
- All FIFOs empty -> idle=1, Pops=0. Reset asserted in the cycle between a pop and its push -> Push stays 0, data_out=0, ptr=0.
